// File: rtl/bus_pkg.sv
// Shared widths, FSM state encoding and response status codes for the bus initiator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bus_pkg;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NCE = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/bus_timeout_counter.sv
// Clear/enable counter that saturates at LIMIT; tc flags the last count before LIMIT.
// Latency: count updates one cycle after en; tc is combinational from count.
// Backpressure: none; en simply stalls the count.
module bus_timeout_counter #(
    parameter int LIMIT = 15,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] MAX_CNT  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX_CNT)) begin
            count <= count + 1'b1;
        end
    end

    // High while the current cycle is the last one allowed before the limit is reached.
    assign tc = (count == LAST_CNT);

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding bus master: request -> decode CE -> strobe until ACK or timeout -> response.
// Latency: accept to RSP_VALID is 2 (unmapped), ACK delay + 2 (mapped) or TIMEOUT + 2 cycles.
// Backpressure: RSP_VALID holds with stable data until RSP_READY; REQ_READY only in IDLE.
module bus_initiator #(
    parameter int AW      = bus_pkg::AW,
    parameter int DW      = bus_pkg::DW,
    parameter int NCE     = bus_pkg::NCE,
    parameter int TIMEOUT = 15
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           REQ_VALID,
    output logic           REQ_READY,
    input  logic [AW-1:0]  REQ_ADDR,
    input  logic           REQ_WRITE,
    input  logic [DW-1:0]  REQ_WDATA,
    output logic           RSP_VALID,
    input  logic           RSP_READY,
    output logic [DW-1:0]  RSP_RDATA,
    output logic [1:0]     RSP_ERR,
    output logic [AW-1:0]  ADDRESS,
    input  logic [NCE-1:0] CE,
    output logic           STB,
    output logic           WE,
    output logic [DW-1:0]  WDATA,
    input  logic           ACK,
    input  logic [DW-1:0]  RDATA
);

    import bus_pkg::*;

    state_t state, state_nxt;
    logic   to_tc;
    logic   ce_hit;

    assign ce_hit = |CE;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk (CLK),
        .rst (RST),
        .clr (state == DECODE),
        .en  ((state == WAIT) && !ACK),
        .tc  (to_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ_VALID) state_nxt = DECODE;
            DECODE:  state_nxt = ce_hit ? WAIT : RESP;
            WAIT:    if (ACK || to_tc) state_nxt = RESP;
            RESP:    if (RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = (state == IDLE);
        RSP_VALID = (state == RESP);
        STB       = (state == WAIT);
    end

    // Bus and response registers; ACK wins over a timeout landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ADDRESS   <= '0;
            WE        <= 1'b0;
            WDATA     <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        ADDRESS <= REQ_ADDR;
                        WE      <= REQ_WRITE;
                        WDATA   <= REQ_WDATA;
                    end
                end
                DECODE: begin
                    if (!ce_hit) begin
                        RSP_ERR   <= ERR_UNMAPPED;
                        RSP_RDATA <= '0;
                    end
                end
                WAIT: begin
                    if (ACK) begin
                        RSP_ERR   <= ERR_OK;
                        RSP_RDATA <= WE ? '0 : RDATA;
                    end else if (to_tc) begin
                        RSP_ERR   <= ERR_TIMEOUT;
                        RSP_RDATA <= '0;
                    end
                end
                RESP: begin
                    if (RSP_READY) WE <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed vector table, reset-in-flight sequence, randomized traffic
// checked against a transaction-level model of decode, ACK timing and timeout.
module tb_bus_initiator;

    import bus_pkg::*;

    localparam int TO = 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] REQ_ADDR;
    logic       REQ_WRITE;
    logic [7:0] REQ_WDATA;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_RDATA;
    logic [1:0] RSP_ERR;
    logic [7:0] ADDRESS;
    logic [1:0] CE;
    logic       STB;
    logic       WE;
    logic [7:0] WDATA;
    logic       ACK;
    logic [7:0] RDATA;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    bus_initiator #(.AW(8), .DW(8), .NCE(2), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .ADDRESS(ADDRESS), .CE(CE), .STB(STB), .WE(WE), .WDATA(WDATA),
        .ACK(ACK), .RDATA(RDATA)
    );

    // Decoder: 0x00-0x3F split even/odd over the two CEs, 0x80-0x8F hits both, rest unmapped.
    function automatic logic [1:0] decode(input logic [7:0] a);
        logic [1:0] c;
        c = 2'b00;
        if (a < 8'h40)                   c = a[0] ? 2'b10 : 2'b01;
        else if (a >= 8'h80 && a < 8'h90) c = 2'b11;
        return c;
    endfunction

    assign CE = decode(ADDRESS);

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic model(input logic [7:0] a, input logic w, input int ackd, input logic [7:0] rd,
                         output logic [1:0] err, output logic [7:0] rdat,
                         output int lat, output int stbn);
        if (decode(a) == 2'b00) begin
            err = ERR_UNMAPPED; rdat = 8'h00; lat = 2; stbn = 0;
        end else if (ackd >= 1 && ackd <= TO) begin
            err = ERR_OK; rdat = w ? 8'h00 : rd; lat = ackd + 2; stbn = ackd;
        end else begin
            err = ERR_TIMEOUT; rdat = 8'h00; lat = TO + 2; stbn = TO;
        end
    endtask

    // One complete transaction. ackd = STB cycle on which the target ACKs (0 = never).
    task automatic run_txn(input logic [7:0] a, input logic w, input logic [7:0] wd,
                           input int ackd, input logic [7:0] rd, input int rwait,
                           input logic [1:0] e_err, input logic [7:0] e_rdat,
                           input int e_lat, input int e_stb);
        int lat;
        int stbn;
        check("req_ready_idle", 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b1; REQ_ADDR = a; REQ_WRITE = w; REQ_WDATA = wd;
        tick;
        REQ_VALID = 1'b0; REQ_ADDR = 8'($urandom); REQ_WRITE = 1'($urandom); REQ_WDATA = 8'($urandom);
        lat = 1; stbn = 0;
        while (!RSP_VALID && lat < 40) begin
            if (STB) begin
                stbn++;
                check("bus_hold", {8'h0, ADDRESS, 7'h0, WE, WDATA}, {8'h0, a, 7'h0, w, wd});
                ACK   = (ackd != 0) && (stbn == ackd);
                RDATA = ACK ? rd : 8'($urandom);
            end else begin
                ACK   = 1'($urandom);
                RDATA = 8'($urandom);
            end
            tick;
            lat++;
        end
        ACK = 1'($urandom);
        check("latency", 32'(lat), 32'(e_lat));
        check("stb_cycles", 32'(stbn), 32'(e_stb));
        for (int i = 0; i < rwait; i++) begin
            check("rsp_hold", {20'h0, RSP_VALID, REQ_READY, RSP_ERR, RSP_RDATA},
                  {20'h0, 1'b1, 1'b0, e_err, e_rdat});
            tick;
        end
        check("rsp", {20'h0, RSP_VALID, REQ_READY, RSP_ERR, RSP_RDATA},
              {20'h0, 1'b1, 1'b0, e_err, e_rdat});
        RSP_READY = 1'b1;
        tick;
        RSP_READY = 1'b0;
        ACK = 1'b0;
        check("post_handshake", {28'h0, REQ_READY, RSP_VALID, STB, WE}, {28'h0, 4'b1000});
    endtask

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wd;
        int         ackd;
        logic [7:0] rd;
        int         rwait;
        logic [1:0] e_err;
        logic [7:0] e_rdat;
        int         e_lat;
        int         e_stb;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [1:0] m_err;
        logic [7:0] m_rdat;
        int         m_lat;
        int         m_stb;
        logic [7:0] ra;
        logic       rw;
        logic [7:0] rwd;
        logic [7:0] rrd;
        int         rack;

        vt[0] = '{8'h01, 1'b0, 8'h00, 1,  8'hA5, 0, 2'b00, 8'hA5, 3,  1};
        vt[1] = '{8'h00, 1'b1, 8'h3C, 4,  8'h77, 0, 2'b00, 8'h00, 6,  4};
        vt[2] = '{8'h7F, 1'b0, 8'h00, 1,  8'h55, 0, 2'b01, 8'h00, 2,  0};
        vt[3] = '{8'h01, 1'b0, 8'h00, 0,  8'h66, 0, 2'b10, 8'h00, 17, 15};
        vt[4] = '{8'h01, 1'b0, 8'h00, 15, 8'h5A, 0, 2'b00, 8'h5A, 17, 15};
        vt[5] = '{8'h02, 1'b0, 8'h00, 2,  8'hC3, 5, 2'b00, 8'hC3, 4,  2};
        vt[6] = '{8'h85, 1'b0, 8'h00, 1,  8'h11, 0, 2'b00, 8'h11, 3,  1};
        vt[7] = '{8'h7F, 1'b1, 8'h99, 1,  8'h22, 2, 2'b01, 8'h00, 2,  0};
        vt[8] = '{8'h03, 1'b1, 8'hE1, 0,  8'h33, 1, 2'b10, 8'h00, 17, 15};

        RST = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 8'hFF; REQ_WRITE = 1'b1; REQ_WDATA = 8'hFF;
        RSP_READY = 1'b0; ACK = 1'b1; RDATA = 8'hFF;
        tick;
        tick;
        check("reset_state",
              {8'h0, REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA, ADDRESS, STB, WE, WDATA[3:0]},
              {8'h0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0});
        check("reset_wdata", 32'(WDATA), 32'd0);
        RST = 1'b0; REQ_VALID = 1'b0; ACK = 1'b0;
        tick;

        for (int i = 0; i < 9; i++) begin
            run_txn(vt[i].addr, vt[i].wr, vt[i].wd, vt[i].ackd, vt[i].rd, vt[i].rwait,
                    vt[i].e_err, vt[i].e_rdat, vt[i].e_lat, vt[i].e_stb);
        end

        // Reset while strobing: STB and the pending transaction must vanish on that edge.
        REQ_VALID = 1'b1; REQ_ADDR = 8'h01; REQ_WRITE = 1'b0; REQ_WDATA = 8'h00;
        tick;
        REQ_VALID = 1'b0;
        tick;
        check("wait_stb", 32'(STB), 32'd1);
        tick;
        tick;
        RST = 1'b1;
        tick;
        check("reset_in_wait", {29'h0, STB, RSP_VALID, REQ_READY}, {29'h0, 3'b001});
        RST = 1'b0;
        run_txn(8'h00, 1'b0, 8'h00, 2, 8'h9E, 0, 2'b00, 8'h9E, 4, 2);

        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom);
            if (i % 3 == 0) ra = 8'($urandom_range(0, 63));
            rw   = 1'($urandom);
            rwd  = 8'($urandom);
            rrd  = 8'($urandom);
            rack = $urandom_range(0, TO + 2);
            model(ra, rw, rack, rrd, m_err, m_rdat, m_lat, m_stb);
            run_txn(ra, rw, rwd, rack, rrd, $urandom_range(0, 3), m_err, m_rdat, m_lat, m_stb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
